map_update_arbiter: RTL



---
 rtl/map_update_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/map_update_arbiter.sv
// map_update_arbiter
// Merges tile-destruction requests from the two tanks into the single write
// port of the shared 20x15 map RAM. Each tank owns a small FIFO; a round-robin
// arbiter picks a FIFO head and runs a read-modify-write applying the tile
// damage rules (brick 2->0, steel 5->6, cracked steel 6->0).
// Optional build macro: MAP_ARB_DUP_FILTER_EN
//   Simultaneous identical hits from both tanks are enqueued once (FIFO 0),
//   and a push equal to the current tail of its own FIFO is dropped silently.
module map_update_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAP_TILES  = 300
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       round_clr,
  input  logic [8:0] req0_idx,
  input  logic [8:0] req1_idx,
  output logic [8:0] ram_addr,
  output logic       ram_rd_en,
  input  logic [2:0] ram_rdata,
  output logic       ram_we,
  output logic [2:0] ram_wdata,
  output logic       busy,
  output logic       ovf0,
  output logic       ovf1,
  output logic       last_grant
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [9:0]       TILE_LIMIT = 10'(MAP_TILES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_MOD  = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  // Tile damage rule: codes not listed are indestructible and stay unchanged.
  function automatic logic [2:0] tile_damage(input logic [2:0] code);
    logic [2:0] res;
    case (code)
      3'd2:    res = 3'd0;
      3'd5:    res = 3'd6;
      3'd6:    res = 3'd0;
      default: res = code;
    endcase
    return res;
  endfunction

  // FIFO storage and bookkeeping, index 0 = tank 0, index 1 = tank 1
  logic [8:0]       mem_r    [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r [2];
  logic [PTR_W-1:0] rd_ptr_r [2];
  logic [CNT_W-1:0] cnt_r    [2];
  logic [1:0]       ovf_r;

  state_t     state_r;
  logic [8:0] addr_r;

  logic [8:0] req_idx_s [2];
  logic [1:0] want_s;
  logic [1:0] push_s;
  logic [1:0] pop_s;
  logic [1:0] drop_s;
  logic [1:0] full_s;
  logic [1:0] ne_s;
  logic       grant_s;
  logic       take_s;
  logic [8:0] head_s;
  logic [2:0] new_code_s;
  logic       code_chg_s;

  // Request qualification, round-robin grant and FIFO push/pop decisions
  always_comb begin
    req_idx_s[0] = req0_idx;
    req_idx_s[1] = req1_idx;
    for (int n = 0; n < 2; n++) begin
      ne_s[n]   = (cnt_r[n] != {CNT_W{1'b0}});
      full_s[n] = (cnt_r[n] == FULL_CNT);
      want_s[n] = (req_idx_s[n] != 9'd0) && ({1'b0, req_idx_s[n]} < TILE_LIMIT) && !round_clr;
    end
`ifdef MAP_ARB_DUP_FILTER_EN
    // A simultaneous double hit on one tile counts once, via FIFO 0.
    if (want_s[0] && want_s[1] && (req0_idx == req1_idx)) begin
      want_s[1] = 1'b0;
    end else begin
      want_s[1] = want_s[1];
    end
    // A repeat of the newest queued index adds nothing; drop it quietly.
    for (int n = 0; n < 2; n++) begin
      if (ne_s[n] && (req_idx_s[n] == mem_r[n][wr_ptr_r[n] - PTR_W'(1)])) begin
        want_s[n] = 1'b0;
      end else begin
        want_s[n] = want_s[n];
      end
    end
`endif
    if (ne_s[0] && ne_s[1]) begin
      grant_s = ~last_grant;
    end else begin
      grant_s = ne_s[1];
    end
    take_s   = (state_r == ST_IDLE) && (ne_s != 2'b00) && !round_clr;
    pop_s[0] = take_s && !grant_s;
    pop_s[1] = take_s && grant_s;
    for (int n = 0; n < 2; n++) begin
      // A full FIFO that pops in the same cycle still has room.
      push_s[n] = want_s[n] && (!full_s[n] || pop_s[n]);
      drop_s[n] = want_s[n] && full_s[n] && !pop_s[n];
    end
    head_s     = mem_r[grant_s][rd_ptr_r[grant_s]];
    new_code_s = tile_damage(ram_rdata);
    code_chg_s = (new_code_s != ram_rdata);
  end

  // FIFO payload storage; contents are only meaningful below the count
  always_ff @(posedge frame_clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push_s[n]) begin
        mem_r[n][wr_ptr_r[n]] <= req_idx_s[n];
      end
    end
  end

  // FIFO pointers, occupancy counts and sticky overflow flags
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_r[n] <= {PTR_W{1'b0}};
        rd_ptr_r[n] <= {PTR_W{1'b0}};
        cnt_r[n]    <= {CNT_W{1'b0}};
      end
      ovf_r <= 2'b00;
    end else if (round_clr) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_r[n] <= {PTR_W{1'b0}};
        rd_ptr_r[n] <= {PTR_W{1'b0}};
        cnt_r[n]    <= {CNT_W{1'b0}};
      end
      ovf_r <= 2'b00;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push_s[n]) begin
          wr_ptr_r[n] <= wr_ptr_r[n] + PTR_W'(1);
        end
        if (pop_s[n]) begin
          rd_ptr_r[n] <= rd_ptr_r[n] + PTR_W'(1);
        end
        case ({push_s[n], pop_s[n]})
          2'b10:   cnt_r[n] <= cnt_r[n] + CNT_W'(1);
          2'b01:   cnt_r[n] <= cnt_r[n] - CNT_W'(1);
          default: cnt_r[n] <= cnt_r[n];
        endcase
      end
      ovf_r <= ovf_r | drop_s;
    end
  end

  // Read-modify-write sequencer driving the registered RAM interface
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      addr_r     <= 9'd0;
      ram_addr   <= 9'd0;
      ram_rd_en  <= 1'b0;
      ram_we     <= 1'b0;
      ram_wdata  <= 3'd0;
      last_grant <= 1'b1;
    end else if (round_clr) begin
      // Abort whatever is in flight; address and grant history are kept.
      state_r   <= ST_IDLE;
      ram_rd_en <= 1'b0;
      ram_we    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ram_we <= 1'b0;
          if (take_s) begin
            addr_r     <= head_s;
            ram_addr   <= head_s;
            ram_rd_en  <= 1'b1;
            last_grant <= grant_s;
            state_r    <= ST_RD;
          end
        end
        ST_RD: begin
          ram_rd_en <= 1'b0;
          state_r   <= ST_MOD;
        end
        ST_MOD: begin
          ram_addr <= addr_r;
          if (code_chg_s) begin
            ram_we    <= 1'b1;
            ram_wdata <= new_code_s;
          end else begin
            ram_we <= 1'b0;
          end
          state_r <= ST_WR;
        end
        ST_WR: begin
          ram_we  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ram_rd_en <= 1'b0;
          ram_we    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_r != ST_IDLE) || (cnt_r[0] != {CNT_W{1'b0}}) || (cnt_r[1] != {CNT_W{1'b0}});
  assign ovf0 = ovf_r[0];
  assign ovf1 = ovf_r[1];

endmodule
